csel_addsub_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready flow control. It generalises the fixed 32-bit, 4-bit-block carry-select adder in three ways: configurable width and block size, add/subtract/carry-chain modes, and status flags. It sits between operand registers and the ALU result mux and sustains one operation per cycle under backpressure.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/csel_block.sv | 14 +
 rtl/csel_addsub_pipe.sv | 186 ++++++++++++++++++
 tb/tb_csel_addsub_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and carry-select block-count helper.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  // Result flags presented alongside the sum.
  typedef struct packed {
    logic co;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Number of carry-select blocks for a given operand and block width.
  function automatic int unsigned nblocks(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One BLK-bit ripple adder slice: sum and carry-out for a fixed carry-in.
module csel_block #(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  assign {co, s} = (BLK+1)'(a) + (BLK+1)'(b) + (BLK+1)'(ci);

endmodule

// File: rtl/csel_addsub_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 precomputes every block sum for both carry-ins; stage 2 resolves the
// block carry chain, selects the sums and derives the status flags.
module csel_addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NB = nblocks(WIDTH, BLK);

  if ((WIDTH % BLK) != 0) begin : g_bad_blk
    $error("csel_addsub_pipe: WIDTH (%0d) must be a multiple of BLK (%0d)", WIDTH, BLK);
  end
  if (WIDTH < 8) begin : g_bad_width
    $error("csel_addsub_pipe: WIDTH (%0d) must be at least 8", WIDTH);
  end

  logic [WIDTH-1:0] b_c;
  logic             c0_c;
  logic             v1_q;
  logic             v2_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] s_q;
  flags_t           flags_q;

  // Handshake: stage 2 refills when empty or drained; stage 1 frees on advance.
  assign adv2      = v1_q && (!v2_q || out_ready);
  assign in_ready  = !v1_q || adv2;
  assign accept    = in_valid && in_ready;
  assign out_valid = v2_q;

  // Operand conditioning: subtraction is a + ~b + 1 (or + ~borrow).
  always_comb begin
    b_c  = b;
    c0_c = 1'b0;
    case (op_e'(op))
      OP_ADD:  begin b_c = b;  c0_c = 1'b0; end
      OP_SUB:  begin b_c = ~b; c0_c = 1'b1; end
      OP_ADDC: begin b_c = b;  c0_c = ci;   end
      OP_SUBB: begin b_c = ~b; c0_c = ~ci;  end
      default: begin b_c = b;  c0_c = 1'b0; end
    endcase
  end

  // Stage-1 valid bit and operand sign bits for overflow detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      v1_q    <= 1'b1;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b_c[WIDTH-1];
    end else if (adv2) begin
      v1_q    <= 1'b0;
    end
  end

  // Per-block adders, stage-1 registers and the stage-2 carry-select chain.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLK-1:0] sel;
    logic           cy;

    if (k == 0) begin : g_lo
      logic [BLK-1:0] sum_d;
      logic           cy_d;
      logic [BLK-1:0] sum_q;
      logic           cy_q;

      csel_block #(.BLK(BLK)) u_add (
        .a  (a[BLK-1:0]),
        .b  (b_c[BLK-1:0]),
        .ci (c0_c),
        .s  (sum_d),
        .co (cy_d)
      );

      // Block 0 sum and carry using the real carry-in.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
          cy_q  <= 1'b0;
        end else if (accept) begin
          sum_q <= sum_d;
          cy_q  <= cy_d;
        end
      end

      assign sel = sum_q;
      assign cy  = cy_q;
    end else begin : g_hi
      logic [BLK-1:0] sum0_d;
      logic [BLK-1:0] sum1_d;
      logic           cy0_d;
      logic           cy1_d;
      logic [BLK-1:0] sum0_q;
      logic [BLK-1:0] sum1_q;
      logic           cy0_q;
      logic           cy1_q;

      csel_block #(.BLK(BLK)) u_add0 (
        .a  (a[k*BLK +: BLK]),
        .b  (b_c[k*BLK +: BLK]),
        .ci (1'b0),
        .s  (sum0_d),
        .co (cy0_d)
      );

      csel_block #(.BLK(BLK)) u_add1 (
        .a  (a[k*BLK +: BLK]),
        .b  (b_c[k*BLK +: BLK]),
        .ci (1'b1),
        .s  (sum1_d),
        .co (cy1_d)
      );

      // Upper block: both speculative results are captured.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum0_q <= '0;
          sum1_q <= '0;
          cy0_q  <= 1'b0;
          cy1_q  <= 1'b0;
        end else if (accept) begin
          sum0_q <= sum0_d;
          sum1_q <= sum1_d;
          cy0_q  <= cy0_d;
          cy1_q  <= cy1_d;
        end
      end

      assign sel = g_blk[k-1].cy ? sum1_q : sum0_q;
      assign cy  = g_blk[k-1].cy ? cy1_q  : cy0_q;
    end

    assign sel_s[k*BLK +: BLK] = sel;
  end

  // Stage-2 result and flags; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      s_q     <= '0;
      flags_q <= '{co: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};
    end else if (adv2) begin
      v2_q         <= 1'b1;
      s_q          <= sel_s;
      flags_q.co   <= g_blk[NB-1].cy;
      flags_q.ovf  <= (a_msb_q == b_msb_q) && (sel_s[WIDTH-1] != a_msb_q);
      flags_q.zero <= ~|sel_s;
      flags_q.neg  <= sel_s[WIDTH-1];
    end else if (v2_q && out_ready) begin
      v2_q         <= 1'b0;
    end
  end

  assign s    = s_q;
  assign co   = flags_q.co;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Self-checking bench: directed cases on a 32/4 instance plus randomized
// streaming against an arithmetic reference on 32/4, 16/8 and 64/4 instances.
module tb_csel_addsub_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv [ND];
  logic        ir [ND];
  logic        ov [ND];
  logic        orr[ND];
  logic        ci_[ND];
  logic        co_[ND];
  logic        ovf_[ND];
  logic        zr [ND];
  logic        ng [ND];
  logic [1:0]  op_[ND];
  logic [63:0] a_ [ND];
  logic [63:0] b_ [ND];
  logic [31:0] s0;
  logic [15:0] s1;
  logic [63:0] s2;
  int          wid[ND] = '{32, 16, 64};

  int checks = 0;
  int errors = 0;

  csel_addsub_pipe #(.WIDTH(32), .BLK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_[0][31:0]), .b(b_[0][31:0]), .ci(ci_[0]), .op(op_[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .s(s0), .co(co_[0]),
    .ovf(ovf_[0]), .zero(zr[0]), .neg(ng[0]));

  csel_addsub_pipe #(.WIDTH(16), .BLK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_[1][15:0]), .b(b_[1][15:0]), .ci(ci_[1]), .op(op_[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .s(s1), .co(co_[1]),
    .ovf(ovf_[1]), .zero(zr[1]), .neg(ng[1]));

  csel_addsub_pipe #(.WIDTH(64), .BLK(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_[2]), .b(b_[2]), .ci(ci_[2]), .op(op_[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .s(s2), .co(co_[2]),
    .ovf(ovf_[2]), .zero(zr[2]), .neg(ng[2]));

  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [65:0] sx(input logic [63:0] v, input int w);
    logic [65:0] t;
    t = 66'(v);
    if (v[w-1]) t = t | ~((66'd1 << w) - 66'd1);
    return $signed(t);
  endfunction

  // Reference: integer arithmetic on the conditioned operands.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op, input logic ci);
    logic [63:0]       bp;
    logic              c0;
    logic [64:0]       sum;
    logic signed [65:0] sr, hi, lo;
    res_t              r;
    case (op)
      OP_ADD:  begin bp = b;  c0 = 1'b0; end
      OP_SUB:  begin bp = ~b; c0 = 1'b1; end
      OP_ADDC: begin bp = b;  c0 = ci;   end
      default: begin bp = ~b; c0 = ~ci;  end
    endcase
    bp     = bp & mask(w);
    sum    = 65'(a & mask(w)) + 65'(bp) + 65'(c0);
    r.s    = sum[63:0] & mask(w);
    r.co   = sum[w];
    sr     = sx(a, w) + sx(bp, w) + $signed({65'd0, c0});
    hi     = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo     = -(66'sd1 <<< (w - 1));
    r.ovf  = (sr > hi) || (sr < lo);
    r.zero = (r.s == 64'd0);
    r.neg  = r.s[w-1];
    return r;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    case ($urandom_range(7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask(w);
  endfunction

  function automatic res_t outs(input int d);
    res_t r;
    case (d)
      0:       r.s = 64'(s0);
      1:       r.s = 64'(s1);
      default: r.s = s2;
    endcase
    r.co   = co_[d];
    r.ovf  = ovf_[d];
    r.zero = zr[d];
    r.neg  = ng[d];
    return r;
  endfunction

  // Single bundle on the 32-bit instance, sampled one edge after acceptance.
  task automatic do_op(input logic [31:0] aa, input logic [31:0] bb, input logic [1:0] oo,
                       input logic cc, output logic acc, output logic vld, output res_t r);
    @(posedge clk); #1;
    a_[0] = 64'(aa); b_[0] = 64'(bb); op_[0] = oo; ci_[0] = cc;
    iv[0] = 1'b1; orr[0] = 1'b1;
    @(negedge clk);
    acc = ir[0];
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vld = ov[0];
    r   = outs(0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_hs dut%0d: out_valid=%b in_ready=%b, required 0 1", d, ov[d], ir[d]);
      end
      checks++;
      if (outs(d) !== res_t'({64'd0, 1'b0, 1'b0, 1'b1, 1'b0})) begin
        errors++;
        $display("FAIL reset_out dut%0d: got %h, required s=0 co=0 ovf=0 zero=1 neg=0", d, outs(d));
      end
    end
  endtask

  task automatic test_add();
    logic acc, vld; res_t r;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, acc, vld, r);
    checks++;
    if (acc !== 1'b1 || vld !== 1'b1) begin
      errors++;
      $display("FAIL add_latency: accept=%b valid=%b, required 1 1", acc, vld);
    end
    checks++;
    if (r.s !== 64'd0 || r.co !== 1'b1 || r.zero !== 1'b1 || r.ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap: s=%h co=%b zero=%b ovf=%b, required 0 1 1 0", r.s, r.co, r.zero, r.ovf);
    end
  endtask

  task automatic test_sub();
    logic acc, vld; res_t r;
    do_op(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, acc, vld, r);
    checks++;
    if (vld !== 1'b1 || r.s !== 64'h7FFF_FFFF || r.co !== 1'b1 || r.ovf !== 1'b1 || r.neg !== 1'b0) begin
      errors++;
      $display("FAIL sub_ovf: valid=%b s=%h co=%b ovf=%b neg=%b, required 1 7fffffff 1 1 0",
               vld, r.s, r.co, r.ovf, r.neg);
    end
  endtask

  task automatic test_chain();
    logic acc, vld; res_t r;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, acc, vld, r);
    checks++;
    if (r.co !== 1'b1) begin
      errors++;
      $display("FAIL chain_lo: co=%b, required 1", r.co);
    end
    do_op(32'h0, 32'h0, OP_ADDC, r.co, acc, vld, r);
    checks++;
    if (vld !== 1'b1 || r.s !== 64'd1 || r.co !== 1'b0) begin
      errors++;
      $display("FAIL chain_hi: valid=%b s=%h co=%b, required 1 1 0", vld, r.s, r.co);
    end
    do_op(32'd5, 32'd7, OP_SUBB, 1'b0, acc, vld, r);
    checks++;
    if (vld !== 1'b1 || r.s !== 64'hFFFF_FFFE || r.co !== 1'b0 || r.neg !== 1'b1) begin
      errors++;
      $display("FAIL subb: valid=%b s=%h co=%b neg=%b, required 1 fffffffe 0 1", vld, r.s, r.co, r.neg);
    end
  endtask

  // Streaming scenario: pattern=1 runs the 32-bit instance with out_ready
  // cycling 1,0,0,1; pattern=0 drives all instances with random handshakes.
  task automatic test_stream(input int nops, input bit pattern);
    res_t mq[ND][4];
    res_t held[ND];
    res_t o, e;
    int   wp[ND], rp[ND], sent[ND], got[ND];
    bit   stl[ND];
    bit   act, done;
    int   budget;
    budget = pattern ? 200 : 40000;
    for (int d = 0; d < ND; d++) begin
      wp[d] = 0; rp[d] = 0; sent[d] = 0; got[d] = 0; stl[d] = 1'b0; held[d] = '0;
    end
    @(posedge clk); #1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      done = 1'b1;
      for (int d = 0; d < ND; d++) begin
        act = !pattern || (d == 0);
        if (act && got[d] < nops) done = 1'b0;
      end
      if (done) break;
      for (int d = 0; d < ND; d++) begin
        act = !pattern || (d == 0);
        if (!act) begin
          iv[d] = 1'b0; orr[d] = 1'b1;
        end else begin
          iv[d]  = (sent[d] < nops) && (pattern || ($urandom_range(3) != 0));
          a_[d]  = pick(wid[d]);
          b_[d]  = pick(wid[d]);
          op_[d] = 2'($urandom_range(3));
          ci_[d] = 1'($urandom_range(1));
          orr[d] = pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ($urandom_range(2) != 0);
        end
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        act = !pattern || (d == 0);
        if (act) begin
          checks++;
          if (ir[d] !== !((wp[d] - rp[d] == 2) && !orr[d])) begin
            errors++;
            $display("FAIL in_ready dut%0d cyc%0d: got %b, required %b", d, cyc, ir[d],
                     !((wp[d] - rp[d] == 2) && !orr[d]));
          end
          o = outs(d);
          if (stl[d]) begin
            checks++;
            if (ov[d] !== 1'b1 || o !== held[d]) begin
              errors++;
              $display("FAIL stall_hold dut%0d cyc%0d: valid=%b out=%h, required 1 %h", d, cyc, ov[d], o, held[d]);
            end
          end
          if (ov[d] === 1'b1 && orr[d]) begin
            checks++;
            if (wp[d] == rp[d]) begin
              errors++;
              $display("FAIL spurious dut%0d cyc%0d: out=%h with no bundle outstanding", d, cyc, o);
            end else begin
              e = mq[d][rp[d] % 4];
              if (o !== e) begin
                errors++;
                $display("FAIL result dut%0d op#%0d: got %h, required %h", d, got[d], o, e);
              end
              rp[d]++;
              got[d]++;
            end
          end
          stl[d]  = (ov[d] === 1'b1) && !orr[d];
          held[d] = o;
          if (iv[d] && ir[d] === 1'b1) begin
            mq[d][wp[d] % 4] = model(wid[d], a_[d], b_[d], op_[d], ci_[d]);
            wp[d]++;
            sent[d]++;
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      act = !pattern || (d == 0);
      if (act) begin
        checks++;
        if (got[d] != nops) begin
          errors++;
          $display("FAIL stream_count dut%0d: received %0d, required %0d", d, got[d], nops);
        end
      end
      iv[d] = 1'b0; orr[d] = 1'b1;
    end
  endtask

  task automatic test_reset_full();
    int cnt;
    @(posedge clk); #1;
    orr[0] = 1'b0; iv[0] = 1'b1; op_[0] = OP_ADD; ci_[0] = 1'b0;
    a_[0] = 64'd1; b_[0] = 64'd2;
    @(posedge clk); #1;
    a_[0] = 64'd3; b_[0] = 64'd4;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: in_ready=%b out_valid=%b, required 0 1", ir[0], ov[0]);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush: out_valid=%b in_ready=%b, required 0 1", ov[0], ir[0]);
    end
    orr[0] = 1'b1; iv[0] = 1'b1; a_[0] = 64'd10; b_[0] = 64'd20;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0] === 1'b1) begin
        cnt++;
        checks++;
        if (s0 !== 32'd30) begin
          errors++;
          $display("FAIL post_reset_value: s=%h, required 1e", s0);
        end
      end
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL post_reset_count: %0d results emitted, required 1", cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b1; a_[d] = '0; b_[d] = '0; op_[d] = 2'b00; ci_[d] = 1'b0;
    end
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_stream(8, 1'b1);
    test_reset_full();
    test_stream(10000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
